// File: rtl/lcd_timing.sv
// lcd_timing: dot/line timing generator with mode decode, LYC compare and interrupt requests
module lcd_timing #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES_PER_FRAME = 154,
    parameter int VISIBLE_LINES   = 144,
    parameter int MODE2_DOTS      = 80,
    parameter int MODE3_DOTS      = 172
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       lcd_en,
    input  logic [7:0] ly_compare,
    input  logic       stat_int_lyc_lc_en,
    input  logic       stat_int_mode2_en,
    input  logic       stat_int_mode1_en,
    input  logic       stat_int_mode0_en,
    output logic [7:0] ly_coord,
    output logic [8:0] dot_count,
    output logic [1:0] flag_mode_n,
    output logic       flag_lyc_ly_eq,
    output logic       int_vblank,
    output logic       int_stat,
    output logic       line_start,
    output logic       frame_start
);
    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LY_LAST   = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] LY_VBLANK = 8'(VISIBLE_LINES);
    localparam logic [8:0] M2_END    = 9'(MODE2_DOTS);
    localparam logic [8:0] M3_END    = 9'(MODE2_DOTS + MODE3_DOTS);

    logic       active_q, active_d;
    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    logic       eq_q, eq_d;
    logic       stat_line_q, stat_line_d;
    logic       int_stat_q, int_stat_d;
    logic [1:0] mode;
    logic       stat_line;

    // Mode decode from registered position, and the OR of all enabled STAT sources
    always_comb begin
        mode = !active_q ? 2'd0 :
               (ly_q >= LY_VBLANK) ? 2'd1 :
               (dot_q < M2_END) ? 2'd2 :
               (dot_q < M3_END) ? 2'd3 : 2'd0;
        stat_line = active_q & ((stat_int_lyc_lc_en & eq_q) |
                                (stat_int_mode2_en & (mode == 2'd2)) |
                                (stat_int_mode1_en & (mode == 2'd1)) |
                                (stat_int_mode0_en & (mode == 2'd0)));
    end

    // Next-state: enable/disable handling, dot/line counting, compare flag and STAT edge detect
    always_comb begin
        active_d    = active_q;
        dot_d       = dot_q;
        ly_d        = ly_q;
        eq_d        = active_q & (ly_q == ly_compare);
        stat_line_d = stat_line;
        int_stat_d  = stat_line & ~stat_line_q;
        if (!lcd_en) begin
            active_d    = 1'b0;
            dot_d       = 9'd0;
            ly_d        = 8'd0;
            stat_line_d = 1'b0;
        end else if (!active_q) begin
            active_d = 1'b1;
        end else begin
            dot_d = (dot_q == DOT_LAST) ? 9'd0 : dot_q + 9'd1;
            if (dot_q == DOT_LAST)
                ly_d = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (nreset) begin
            active_q    <= 1'b0;
            dot_q       <= 9'd0;
            ly_q        <= 8'd0;
            eq_q        <= 1'b0;
            stat_line_q <= 1'b0;
            int_stat_q  <= 1'b0;
        end else begin
            active_q    <= active_d;
            dot_q       <= dot_d;
            ly_q        <= ly_d;
            eq_q        <= eq_d;
            stat_line_q <= stat_line_d;
            int_stat_q  <= int_stat_d;
        end
    end

    assign ly_coord       = ly_q;
    assign dot_count      = dot_q;
    assign flag_mode_n    = mode;
    assign flag_lyc_ly_eq = eq_q;
    assign int_stat       = int_stat_q;
    assign int_vblank     = active_q & (ly_q == LY_VBLANK) & (dot_q == 9'd0);
    assign line_start     = active_q & (dot_q == 9'd0);
    assign frame_start    = active_q & (ly_q == 8'd0) & (dot_q == 9'd0);
endmodule

// File: tb/tb_lcd_timing.sv
// tb_lcd_timing: directed stimulus against a time-based behavioural model of lcd_timing
module tb_lcd_timing;
    localparam int FRAME = 456 * 154;

    logic       clock = 1'b0;
    logic       nreset = 1'b1;
    logic       lcd_en = 1'b0;
    logic [7:0] ly_compare = 8'd5;
    logic       lyc_en = 1'b0, m2_en = 1'b0, m1_en = 1'b0, m0_en = 1'b0;
    logic [7:0] ly_coord;
    logic [8:0] dot_count;
    logic [1:0] flag_mode_n;
    logic       flag_lyc_ly_eq, int_vblank, int_stat, line_start, frame_start;

    int errors = 0;
    int checks = 0;

    lcd_timing dut (
        .clock(clock), .nreset(nreset), .lcd_en(lcd_en), .ly_compare(ly_compare),
        .stat_int_lyc_lc_en(lyc_en), .stat_int_mode2_en(m2_en),
        .stat_int_mode1_en(m1_en), .stat_int_mode0_en(m0_en),
        .ly_coord(ly_coord), .dot_count(dot_count), .flag_mode_n(flag_mode_n),
        .flag_lyc_ly_eq(flag_lyc_ly_eq), .int_vblank(int_vblank), .int_stat(int_stat),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    // Model: position is just the number of active cycles since enable, mod one frame
    logic m_active = 1'b0;
    int   m_t = 0;
    logic m_eq = 1'b0, m_slq = 1'b0, m_int = 1'b0;

    function automatic logic [1:0] mode_of(input logic act, input int t);
        int ly, dot;
        ly  = t / 456;
        dot = t % 456;
        if (!act) return 2'd0;
        if (ly >= 144) return 2'd1;
        if (dot < 80) return 2'd2;
        if (dot < 252) return 2'd3;
        return 2'd0;
    endfunction

    always @(posedge clock) begin : mdl
        logic [1:0] md;
        logic sl;
        md = mode_of(m_active, m_t);
        sl = m_active && ((lyc_en && m_eq) || (m2_en && md == 2'd2) ||
                          (m1_en && md == 2'd1) || (m0_en && md == 2'd0));
        if (nreset) begin
            m_active <= 1'b0; m_t <= 0; m_eq <= 1'b0; m_slq <= 1'b0; m_int <= 1'b0;
        end else begin
            m_int <= sl && !m_slq;
            m_eq  <= m_active && ((m_t / 456) == int'(ly_compare));
            if (!lcd_en) begin
                m_active <= 1'b0; m_t <= 0; m_slq <= 1'b0;
            end else begin
                m_slq <= sl;
                if (m_active) m_t <= (m_t + 1) % FRAME;
                else m_active <= 1'b1;
            end
        end
    end

    logic [24:0] dut_v;
    assign dut_v = {ly_coord, dot_count, flag_mode_n, flag_lyc_ly_eq, int_vblank, int_stat,
                    line_start, frame_start};

    always @(negedge clock) begin : cmp
        int ly, dot;
        logic [24:0] exp_v;
        ly  = m_active ? m_t / 456 : 0;
        dot = m_active ? m_t % 456 : 0;
        exp_v = {8'(ly), 9'(dot), mode_of(m_active, m_t), m_eq,
                 m_active && ly == 144 && dot == 0, m_int,
                 m_active && dot == 0, m_active && ly == 0 && dot == 0};
        checks++;
        if (dut_v !== exp_v) begin
            errors++;
            $display("FAIL model t=%0t got=%h exp=%h", $time, dut_v, exp_v);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        step(3);
        check("reset_outputs", 32'(dut_v), 0);
        nreset = 1'b0; lcd_en = 1'b1;
        step(1);
        check("first_mode", 32'(flag_mode_n), 2);
        check("first_frame_start", 32'(frame_start), 1);
        step(80);
        check("dot80_mode", 32'(flag_mode_n), 3);
        step(171);
        check("dot251_mode", 32'(flag_mode_n), 3);
        step(1);
        check("dot252_mode", 32'(flag_mode_n), 0);
        step(203);
        check("dot455", 32'(dot_count), 455);
        step(1);
        check("wrap_dot", 32'(dot_count), 0);
        check("wrap_ly", 32'(ly_coord), 1);
        check("wrap_line_start", 32'(line_start), 1);
        check("wrap_frame_start", 32'(frame_start), 0);
        lyc_en = 1'b1;
        step(1824);
        check("ly5", 32'(ly_coord), 5);
        check("ly5_eq_lag", 32'(flag_lyc_ly_eq), 0);
        step(1);
        check("ly5_eq", 32'(flag_lyc_ly_eq), 1);
        check("ly5_int_lag", 32'(int_stat), 0);
        step(1);
        check("lyc_int", 32'(int_stat), 1);
        step(1);
        check("lyc_int_one", 32'(int_stat), 0);
        step(453);
        check("ly6_eq_hold", 32'(flag_lyc_ly_eq), 1);
        step(1);
        check("ly6_eq_drop", 32'(flag_lyc_ly_eq), 0);
        lyc_en = 1'b0;
        step(1);
        m0_en = 1'b1; m2_en = 1'b1;
        step(1);
        check("m2_live_int", 32'(int_stat), 1);
        step(1);
        check("m2_int_one", 32'(int_stat), 0);
        step(249);
        check("m0_int", 32'(int_stat), 1);
        step(204);
        check("m0_m2_blocked", 32'(int_stat), 0);
        lyc_en = 1'b1; ly_compare = 8'd10;
        step(62470);
        check("ly143_vblank", 32'(int_vblank), 0);
        step(1);
        check("vblank", 32'(int_vblank), 1);
        check("vblank_mode", 32'(flag_mode_n), 1);
        step(1);
        check("vblank_one", 32'(int_vblank), 0);
        step(4559);
        check("frame_ly", 32'(ly_coord), 0);
        check("frame_start", 32'(frame_start), 1);
        step(1112);
        check("drop_pos", 32'({ly_coord, dot_count}), 32'({8'd2, 9'd200}));
        lcd_en = 1'b0;
        step(1);
        check("drop_outputs", 32'(dut_v), 0);
        step(2);
        check("off_outputs", 32'(dut_v), 0);
        lcd_en = 1'b1;
        step(1);
        check("restart_mode", 32'(flag_mode_n), 2);
        check("restart_int", 32'(int_stat), 0);
        step(1);
        check("restart_m2_int", 32'(int_stat), 1);
        step(1667);
        check("rst_pos", 32'({ly_coord, dot_count}), 32'({8'd3, 9'd300}));
        nreset = 1'b1;
        step(1);
        check("rst_outputs", 32'(dut_v), 0);
        nreset = 1'b0;
        step(1);
        check("rel_mode", 32'(flag_mode_n), 2);
        check("rel_line_start", 32'(line_start), 1);
        step(1);
        check("rel_m2_int", 32'(int_stat), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
